branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands, PC, immediate and targets.
REQ-002 Parameter ROB_IDX_W, default 5, width of the ROB tag carried with each branch.
REQ-003 Parameter CNT_W, default 32, width of the resolved and mispredict counters.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  kills every in-flight entry this cycle.
REQ-007 in_valid / in_ready  in / out  1 / 1  issue handshake; transfer when both high.
REQ-008 in_op  in  br_ops  beq, bne, blt, bltu, bge, bgeu, jal, jalr.
REQ-009 in_rs1, in_rs2, in_pc, in_imm  in  XLEN each  operands, instruction PC, sign-extended immediate.
REQ-010 in_pred_taken, in_pred_target  in  1, XLEN  frontend prediction.
REQ-011 in_rob_idx  in  ROB_IDX_W  tag.
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-013 out_rob_idx, out_taken, out_mispredict  out  ROB_IDX_W, 1, 1  resolved tag, direction, misprediction flag.
REQ-014 out_redirect_pc, out_link  out  XLEN each  correct next PC; pc+4 for jal/jalr writeback.
REQ-015 resolved_cnt, mispred_cnt  out  CNT_W each  statistics counters.

Function
REQ-016 Two registered stages: stage A captures accepted inputs; stage B holds the resolved result, which drives all out_* ports.
REQ-017 Latency SHALL be exactly 2 cycles from in handshake to out_valid when out_ready is held high.
REQ-018 Stage B advances when !B_valid or out_ready; stage A advances when stage B advances; in_ready = !A_valid or A advances (combinational, no bubble at full throughput).
REQ-019 With out_ready low and both stages full, in_ready SHALL be 0 and all stage contents SHALL hold unchanged.
REQ-020 Compares: beq/bne equality; blt/bge signed; bltu/bgeu unsigned; jal, jalr taken=1.
REQ-021 Target: branches and jal = pc+imm; jalr = (rs1+imm) with bit 0 cleared; all sums modulo 2^XLEN.
REQ-022 out_redirect_pc = target if taken else pc+4; out_link = pc+4, modulo 2^XLEN.
REQ-023 out_mispredict = (taken != pred_taken) or (taken and target != pred_target).
REQ-024 flush SHALL clear A_valid and B_valid next edge, discard any same-cycle input transfer and suppress any counter update that cycle; out_valid is 0 the cycle after flush.
REQ-025 resolved_cnt increments on each out handshake; mispred_cnt increments on each out handshake with out_mispredict=1; both wrap at 2^CNT_W.
REQ-026 Undefined in_op with in_valid SHALL resolve as not-taken, mispredict = pred_taken.

Reset
REQ-027 On rst: A_valid=0, B_valid=0, out_valid=0, resolved_cnt=0, mispred_cnt=0; in_ready=1 immediately.
REQ-028 Reset asserted mid-operation SHALL drop all in-flight entries without producing an output.
REQ-029 Datapath registers other than valids and counters need no reset value.

Structure
REQ-030 br_ops enum (with jal, jalr added) and a resolved-branch packed struct SHALL live in magic_backend_types.
REQ-031 One sub-module branch_compare (parameter XLEN; inputs a, b, op; output taken) SHALL hold the comparator.

Verification
REQ-032 bltu rs1=0xFFFF_FFFF, rs2=1 -> not taken; blt same operands -> taken; both at cycle+2.
REQ-033 beq rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> taken, redirect 0x120, mispredict=1, mispred_cnt=1.
REQ-034 jalr rs1=0x1001, imm=2, pred_target=0x1002, pred_taken=1 -> redirect 0x1002, link=pc+4, mispredict=0.
REQ-035 Back-to-back issue of 3 branches with out_ready low 4 cycles -> in_ready=0 after 2 accepted, outputs stable; release -> 3 results in order, no loss.
REQ-036 flush while both stages full, in_valid=1 -> out_valid=0 next cycle, counters unchanged, next issue resolves 2 cycles later.
REQ-037 CNT_W=4, 17 resolved branches -> resolved_cnt=1; rst mid-stream -> out_valid=0 and counters 0 same cycle.

Source files
------------

// File: rtl/magic_backend_types.sv
// Shared backend types for branch resolution: the branch opcode set and the
// flag pair that summarises a resolved branch.
package magic_backend_types;

    // Four bits wide so that encodings 8..15 stay free and reach the
    // comparator as undefined opcodes.
    typedef enum logic [3:0] {
        BR_BEQ  = 4'd0,
        BR_BNE  = 4'd1,
        BR_BLT  = 4'd2,
        BR_BLTU = 4'd3,
        BR_BGE  = 4'd4,
        BR_BGEU = 4'd5,
        BR_JAL  = 4'd6,
        BR_JALR = 4'd7
    } br_ops;

    // Direction and prediction verdict of one resolved branch. The wide,
    // XLEN-dependent fields stay in the parameterised module.
    typedef struct packed {
        logic taken;
        logic mispredict;
    } br_resolved_t;

    // Fall-through distance and link offset for a 32-bit instruction.
    localparam int unsigned BR_INSN_BYTES = 4;

endpackage

// File: rtl/branch_compare.sv
// Branch condition evaluator: decides taken/not-taken from two operands.
module branch_compare
    import magic_backend_types::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  br_ops           op,
    output logic            taken
);

    // Condition select; jumps are always taken, undefined opcodes never are.
    always_comb begin
        taken = 1'b0;
        case (op)
            BR_BEQ:  taken = (a == b);
            BR_BNE:  taken = (a != b);
            BR_BLT:  taken = ($signed(a) < $signed(b));
            BR_BGE:  taken = !($signed(a) < $signed(b));
            BR_BLTU: taken = (a < b);
            BR_BGEU: taken = !(a < b);
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Two-stage branch resolution unit: stage A captures issued branches, stage B
// holds the resolved result that drives the output handshake and statistics.
module branch_unit
    import magic_backend_types::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  br_ops                in_op,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_imm,
    input  logic                 in_pred_taken,
    input  logic [XLEN-1:0]      in_pred_target,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROB_IDX_W-1:0] out_rob_idx,
    output logic                 out_taken,
    output logic                 out_mispredict,
    output logic [XLEN-1:0]      out_redirect_pc,
    output logic [XLEN-1:0]      out_link,
    output logic [CNT_W-1:0]     resolved_cnt,
    output logic [CNT_W-1:0]     mispred_cnt
);

    // Stage A: raw issued branch
    logic                 a_valid;
    br_ops                a_op;
    logic [XLEN-1:0]      a_rs1;
    logic [XLEN-1:0]      a_rs2;
    logic [XLEN-1:0]      a_pc;
    logic [XLEN-1:0]      a_imm;
    logic                 a_pred_taken;
    logic [XLEN-1:0]      a_pred_target;
    logic [ROB_IDX_W-1:0] a_rob_idx;

    // Stage B: resolved branch
    logic                 b_valid;
    br_resolved_t         b_res;
    logic [ROB_IDX_W-1:0] b_rob_idx;
    logic [XLEN-1:0]      b_redirect_pc;
    logic [XLEN-1:0]      b_link;

    // Handshake control
    logic b_adv;
    logic in_fire;
    logic out_fire;

    // Resolution of the stage A entry
    logic            a_taken;
    logic [XLEN-1:0] a_jalr_sum;
    logic [XLEN-1:0] a_target;
    logic [XLEN-1:0] a_link;
    logic [XLEN-1:0] a_redirect_pc;
    br_resolved_t    a_res;

    // Pipeline flow: A moves whenever B moves, so in_ready sees a slot that
    // frees up in this same cycle and full throughput has no bubble.
    always_comb begin
        b_adv    = !b_valid || out_ready;
        in_ready = !a_valid || b_adv;
        in_fire  = in_valid && in_ready && !flush;
        out_fire = b_valid && out_ready && !flush;
    end

    branch_compare #(
        .XLEN(XLEN)
    ) u_compare (
        .a     (a_rs1),
        .b     (a_rs2),
        .op    (a_op),
        .taken (a_taken)
    );

    // Target, fall-through and prediction check for the entry in stage A.
    always_comb begin
        a_jalr_sum = a_rs1 + a_imm;
        a_link     = a_pc + XLEN'(BR_INSN_BYTES);
        if (a_op == BR_JALR) begin
            a_target = {a_jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            a_target = a_pc + a_imm;
        end
        a_redirect_pc    = a_taken ? a_target : a_link;
        a_res.taken      = a_taken;
        a_res.mispredict = (a_taken != a_pred_taken) ||
                           (a_taken && (a_target != a_pred_target));
    end

    // Occupancy and statistics; flush empties both stages and masks counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid      <= 1'b0;
            b_valid      <= 1'b0;
            resolved_cnt <= '0;
            mispred_cnt  <= '0;
        end else if (flush) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            if (b_adv) begin
                b_valid <= a_valid;
            end
            if (in_ready) begin
                a_valid <= in_valid;
            end
            if (out_fire) begin
                resolved_cnt <= resolved_cnt + CNT_W'(1);
                if (b_res.mispredict) begin
                    mispred_cnt <= mispred_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Datapath capture; payload is meaningful only alongside its valid bit.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            a_op          <= in_op;
            a_rs1         <= in_rs1;
            a_rs2         <= in_rs2;
            a_pc          <= in_pc;
            a_imm         <= in_imm;
            a_pred_taken  <= in_pred_taken;
            a_pred_target <= in_pred_target;
            a_rob_idx     <= in_rob_idx;
        end
        if (b_adv && a_valid) begin
            b_res         <= a_res;
            b_rob_idx     <= a_rob_idx;
            b_redirect_pc <= a_redirect_pc;
            b_link        <= a_link;
        end
    end

    assign out_valid       = b_valid;
    assign out_rob_idx     = b_rob_idx;
    assign out_taken       = b_res.taken;
    assign out_mispredict  = b_res.mispredict;
    assign out_redirect_pc = b_redirect_pc;
    assign out_link        = b_link;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: constant vector table, hand-written
// stall/flush/reset sequences and randomized traffic against a queue model.
module tb_branch_unit;
    import magic_backend_types::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, in_pred_taken;
    br_ops       in_op;
    logic [31:0] in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
    logic [4:0]  in_rob_idx;

    logic        in_ready, out_valid, out_taken, out_mispredict;
    logic [4:0]  out_rob_idx;
    logic [31:0] out_redirect_pc, out_link, resolved_cnt, mispred_cnt;

    logic        o4_in_ready, o4_out_valid, o4_taken, o4_mis;
    logic [4:0]  o4_rob;
    logic [31:0] o4_redir, o4_link;
    logic [3:0]  o4_res_cnt, o4_mis_cnt;

    always #5 clk = ~clk;

    branch_unit #(.XLEN(32), .ROB_IDX_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_rob_idx(in_rob_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob_idx(out_rob_idx),
        .out_taken(out_taken), .out_mispredict(out_mispredict),
        .out_redirect_pc(out_redirect_pc), .out_link(out_link),
        .resolved_cnt(resolved_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_unit #(.XLEN(32), .ROB_IDX_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o4_in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_rob_idx(in_rob_idx),
        .out_valid(o4_out_valid), .out_ready(out_ready), .out_rob_idx(o4_rob),
        .out_taken(o4_taken), .out_mispredict(o4_mis),
        .out_redirect_pc(o4_redir), .out_link(o4_link),
        .resolved_cnt(o4_res_cnt), .mispred_cnt(o4_mis_cnt)
    );

    typedef struct {
        logic [4:0]  rob;
        logic        taken;
        logic        mis;
        logic [31:0] redir;
        logic [31:0] link;
        logic        in_b;
    } exp_t;

    typedef struct {
        br_ops       op;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_taken, e_mis;
        logic [31:0] e_redir, e_link;
    } vec_t;

    exp_t        q[$];
    int unsigned cnt_res, cnt_mis;
    int          n_acc, n_out;
    int          errors, checks;
    vec_t        vt[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference resolution from the ISA rules; signed order via sign-bit flip.
    function automatic exp_t predict(br_ops op, logic [31:0] a, logic [31:0] b,
                                     logic [31:0] pc, logic [31:0] imm, logic pt,
                                     logic [31:0] ptgt, logic [4:0] rob);
        exp_t        e;
        logic [31:0] tgt;
        logic        t;
        tgt = pc + imm;
        case (op)
            BR_BEQ:  t = (a == b);
            BR_BNE:  t = (a != b);
            BR_BLT:  t = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
            BR_BGE:  t = !((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
            BR_BLTU: t = (a < b);
            BR_BGEU: t = !(a < b);
            BR_JAL:  t = 1'b1;
            BR_JALR: begin t = 1'b1; tgt = ((a + imm) >> 1) << 1; end
            default: t = 1'b0;
        endcase
        e.rob   = rob;
        e.taken = t;
        e.mis   = (t != pt) || (t && (tgt != ptgt));
        e.link  = pc + 32'd4;
        e.redir = t ? tgt : pc + 32'd4;
        e.in_b  = 1'b0;
        return e;
    endfunction

    function automatic logic mdl_out_valid();
        return (q.size() > 0) && q[0].in_b;
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle();
        exp_t e;
        logic acc, ohs;
        #1;
        check("in_ready", in_ready, (q.size() < 2) || out_ready);
        check("out_valid", out_valid, mdl_out_valid());
        if (mdl_out_valid()) begin
            e = q[0];
            check("out_rob_idx", out_rob_idx, e.rob);
            check("out_taken", out_taken, e.taken);
            check("out_mispredict", out_mispredict, e.mis);
            check("out_redirect_pc", out_redirect_pc, e.redir);
            check("out_link", out_link, e.link);
        end
        check("resolved_cnt", resolved_cnt, cnt_res);
        check("mispred_cnt", mispred_cnt, cnt_mis);
        check("resolved_cnt4", o4_res_cnt, cnt_res & 32'hF);
        check("mispred_cnt4", o4_mis_cnt, cnt_mis & 32'hF);
        acc = !flush && in_valid && ((q.size() < 2) || out_ready);
        ohs = mdl_out_valid() && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (ohs) begin
                e = q.pop_front();
                cnt_res++;
                if (e.mis) cnt_mis++;
                n_out++;
            end
            if (q.size() > 0 && !q[0].in_b) begin
                e = q.pop_front();
                e.in_b = 1'b1;
                q.push_front(e);
            end
            if (acc) begin
                q.push_back(predict(in_op, in_rs1, in_rs2, in_pc, in_imm,
                                    in_pred_taken, in_pred_target, in_rob_idx));
                n_acc++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_resolved_cnt", resolved_cnt, 32'd0);
        check("rst_mispred_cnt", mispred_cnt, 32'd0);
        check("rst_resolved_cnt4", o4_res_cnt, 4'd0);
        q.delete();
        cnt_res = 0;
        cnt_mis = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_in(input logic [4:0] rob);
        in_op  = br_ops'(4'($urandom_range(0, 9)));
        in_rs1 = $urandom;
        in_rs2 = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom;
        in_pc  = {$urandom_range(0, 32'hFFFF), 2'b00};
        in_imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : -32'($urandom_range(0, 255));
        in_pred_taken  = 1'($urandom_range(0, 1));
        in_pred_target = ($urandom_range(0, 1) == 0) ? in_pc + in_imm : $urandom;
        in_rob_idx     = rob;
    endtask

    task automatic apply_vec(input vec_t v, input logic [4:0] rob);
        in_op = v.op; in_rs1 = v.rs1; in_rs2 = v.rs2; in_pc = v.pc; in_imm = v.imm;
        in_pred_taken = v.pt; in_pred_target = v.ptgt; in_rob_idx = rob;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_redir, snap_link, save_res, save_mis;
        logic [4:0]  snap_rob;
        int          acc0, out0;

        errors = 0; checks = 0; n_acc = 0; n_out = 0; cnt_res = 0; cnt_mis = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = BR_BEQ; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0;
        in_pred_taken = 1'b0; in_pred_target = '0; in_rob_idx = '0;

        //              op            rs1            rs2       pc             imm            pt    ptgt           taken mis   redirect       link
        vt[0]  = '{BR_BEQ,       32'd5,         32'd5,    32'h100,       32'h20,        1'b0, 32'h0,         1'b1, 1'b1, 32'h120,       32'h104};
        vt[1]  = '{BR_BLTU,      32'hFFFF_FFFF, 32'd1,    32'h200,       32'h40,        1'b0, 32'h0,         1'b0, 1'b0, 32'h204,       32'h204};
        vt[2]  = '{BR_BLT,       32'hFFFF_FFFF, 32'd1,    32'h200,       32'h40,        1'b0, 32'h0,         1'b1, 1'b1, 32'h240,       32'h204};
        vt[3]  = '{BR_JALR,      32'h1001,      32'd0,    32'h300,       32'd2,         1'b1, 32'h1002,      1'b1, 1'b0, 32'h1002,      32'h304};
        vt[4]  = '{BR_BNE,       32'd7,         32'd7,    32'h400,       32'h8,         1'b1, 32'h408,       1'b0, 1'b1, 32'h404,       32'h404};
        vt[5]  = '{BR_BGE,       32'hFFFF_FFFD, 32'd2,    32'h500,       32'hFFFF_FFF0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h504,       32'h504};
        vt[6]  = '{BR_BGEU,      32'hFFFF_FFFD, 32'd2,    32'h500,       32'hFFFF_FFF0, 1'b1, 32'h4F0,       1'b1, 1'b0, 32'h4F0,       32'h504};
        vt[7]  = '{BR_JAL,       32'd0,         32'd0,    32'hFFFF_FFF8, 32'h10,        1'b1, 32'h8,         1'b1, 1'b0, 32'h8,         32'hFFFF_FFFC};
        vt[8]  = '{BR_JAL,       32'd0,         32'd0,    32'h600,       32'h10,        1'b1, 32'h614,       1'b1, 1'b1, 32'h610,       32'h604};
        vt[9]  = '{br_ops'(4'hF), 32'd3,        32'd3,    32'h700,       32'h10,        1'b1, 32'h710,       1'b0, 1'b1, 32'h704,       32'h704};
        vt[10] = '{BR_BNE,       32'd1,         32'd2,    32'hFFFF_FFFC, 32'h4,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h0};

        @(negedge clk);
        do_reset();

        // Table: each vector alone, result exactly two cycles after issue.
        for (int i = 0; i < 11; i++) begin
            apply_vec(vt[i], 5'(i));
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            #1;
            check("lat_not_early", out_valid, 1'b0);
            cycle();
            #1;
            check("tbl_out_valid", out_valid, 1'b1);
            check("tbl_rob", out_rob_idx, 5'(i));
            check("tbl_taken", out_taken, vt[i].e_taken);
            check("tbl_mispredict", out_mispredict, vt[i].e_mis);
            check("tbl_redirect", out_redirect_pc, vt[i].e_redir);
            check("tbl_link", out_link, vt[i].e_link);
            cycle();
            if (i == 0) begin
                check("beq_resolved_cnt", resolved_cnt, 32'd1);
                check("beq_mispred_cnt", mispred_cnt, 32'd1);
            end
        end

        // Backpressure: three back-to-back branches, out_ready low 4 cycles.
        out_ready = 1'b0;
        acc0 = n_acc; out0 = n_out;
        snap_redir = '0; snap_link = '0; snap_rob = '0;
        for (int c = 0; c < 4; c++) begin
            rand_in(5'(20 + n_acc - acc0));
            in_valid = (n_acc - acc0) < 3;
            cycle();
            if (c == 1) begin
                snap_redir = out_redirect_pc; snap_link = out_link; snap_rob = out_rob_idx;
            end
        end
        #1;
        check("stall_accepted", 32'(n_acc - acc0), 32'd2);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_redirect_hold", out_redirect_pc, snap_redir);
        check("stall_link_hold", out_link, snap_link);
        check("stall_rob_hold", out_rob_idx, snap_rob);
        out_ready = 1'b1;
        for (int c = 0; c < 12 && (n_out - out0) < 3; c++) begin
            if ((n_acc - acc0) < 3) rand_in(5'(20 + n_acc - acc0));
            in_valid = (n_acc - acc0) < 3;
            cycle();
        end
        in_valid = 1'b0;
        check("stall_drained", 32'(n_out - out0), 32'd3);

        // Flush with both stages full and an input offered in the same cycle.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            rand_in(5'(c));
            in_valid = 1'b1;
            cycle();
        end
        save_res = resolved_cnt; save_mis = mispred_cnt;
        out_ready = 1'b1;
        flush = 1'b1;
        rand_in(5'd9);
        in_valid = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_resolved_hold", resolved_cnt, save_res);
        check("flush_mispred_hold", mispred_cnt, save_mis);
        cycle();
        rand_in(5'd11);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        #1;
        check("post_flush_valid", out_valid, 1'b1);
        check("post_flush_rob", out_rob_idx, 5'd11);
        cycle();

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            rand_in(5'(n_acc));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();

        // Narrow counter wrap: 17 resolved branches leave a 4-bit count of 1.
        do_reset();
        acc0 = n_acc; out0 = n_out;
        for (int c = 0; c < 30 && (n_out - out0) < 17; c++) begin
            rand_in(5'(n_acc));
            in_valid = (n_acc - acc0) < 17;
            cycle();
        end
        in_valid = 1'b0;
        check("wrap_resolved_cnt4", o4_res_cnt, 4'd1);
        check("wrap_resolved_cnt", resolved_cnt, 32'd17);

        // Reset mid-stream drops everything in the same cycle.
        for (int c = 0; c < 3; c++) begin
            rand_in(5'(c));
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        #1;
        check("pre_rst_out_valid", out_valid, 1'b1);
        do_reset();
        for (int c = 0; c < 3; c++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
